dtw_ref_mem_ctrl: RTL and testbench

Sequencer and arbiter for the DTW reference-sample memory. Accepts a host load stream that writes reference samples into the memory from address 0 upward and records the loaded length. On command, scans the stored reference in address order into a valid/ready sample stream for the DTW core. Load and scan share the single memory and never overlap; the controller enforces that.

---
 rtl/dtw_pkg.sv | 16 +
 rtl/dtw_ref_out_reg.sv | 36 +++
 rtl/dtw_ref_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_dtw_ref_mem_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and defaults for the DTW reference-memory controller.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dtw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2
   } state_t;

   localparam int WIDTH_DEF   = 16;
   localparam int PTR_WID_DEF = 15;
   localparam int CNT_WID     = 16;

endpackage

// File: rtl/dtw_ref_out_reg.sv
// One-entry valid/ready output register carrying a sample plus its last flag.
// Latency: one cycle from load to out_valid.
// Backpressure: in_ready is high when empty or when the held entry is consumed this cycle.
module dtw_ref_out_reg #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data,
   output logic             out_last
);

   assign in_ready = !out_valid || out_ready;

   // Capture a new entry when there is room; otherwise drain once the held entry is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dtw_ref_mem_ctrl.sv
// Load/scan sequencer for the DTW reference memory; optional scan counter under DTW_REF_CTRL_STATS_EN.
// Latency: load writes in the handshake cycle; first scan sample two cycles after scan_start.
// Backpressure: ld_ready low during a scan; sample stream holds data while sample_ready is low.
module dtw_ref_mem_ctrl
   import dtw_pkg::*;
#(
   parameter int width  = WIDTH_DEF,
   parameter int ptrWid = PTR_WID_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [width-1:0]   ld_data,
   input  logic               ld_last,
   input  logic               scan_start,
   output logic               scan_busy,
   output logic               scan_done,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic [width-1:0]   sample_data,
   output logic               sample_last,
   output logic [ptrWid:0]    ref_len,
   output logic [CNT_WID-1:0] scan_count,
   output logic [ptrWid-1:0]  mem_addrR,
   output logic [ptrWid-1:0]  mem_addrW,
   output logic               mem_wren,
   output logic [width-1:0]   mem_datain,
   input  logic [width-1:0]   mem_dataout
);

   localparam logic [ptrWid:0]   LEN_ONE  = {{ptrWid{1'b0}}, 1'b1};
   localparam logic [ptrWid-1:0] ADDR_ONE = {{(ptrWid-1){1'b0}}, 1'b1};
   localparam logic [ptrWid-1:0] ADDR_MAX = '1;

   state_t            state, state_nxt;
   logic [ptrWid-1:0] wr_ptr, wr_ptr_nxt;
   logic [ptrWid:0]   rd_ptr, rd_ptr_nxt, ref_len_nxt;
   logic              done_nxt;
   logic              ld_acc, ld_end;
   logic              fetch_valid, fetch_ready, fetch;
   logic              sample_acc;

   // Load is accepted whenever no scan owns the memory; the last address closes the load.
   assign ld_ready    = !rst && (state != SCAN);
   assign ld_acc      = ld_valid && ld_ready;
   assign ld_end      = ld_acc && (ld_last || (wr_ptr == ADDR_MAX));
   assign mem_wren    = ld_acc;
   assign mem_addrW   = ld_acc ? wr_ptr : '0;
   assign mem_datain  = ld_acc ? ld_data : '0;

   assign scan_busy   = (state == SCAN);
   assign mem_addrR   = scan_busy ? rd_ptr[ptrWid-1:0] : '0;
   assign fetch_valid = scan_busy && (rd_ptr < ref_len);
   assign fetch       = fetch_valid && fetch_ready;
   assign sample_acc  = sample_valid && sample_ready;

   // Next-state, pointer and length updates; a load beat in IDLE takes priority over scan_start.
   always_comb begin
      state_nxt   = state;
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      ref_len_nxt = ref_len;
      done_nxt    = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (ld_acc) begin
               if (ld_end) begin
                  state_nxt   = IDLE;
                  wr_ptr_nxt  = '0;
                  ref_len_nxt = {1'b0, wr_ptr} + LEN_ONE;
               end else begin
                  state_nxt  = LOAD;
                  wr_ptr_nxt = wr_ptr + ADDR_ONE;
               end
            end else if ((state == IDLE) && scan_start) begin
               if (ref_len == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt  = SCAN;
                  rd_ptr_nxt = '0;
               end
            end
         end
         SCAN: begin
            if (fetch) begin
               rd_ptr_nxt = rd_ptr + LEN_ONE;
            end
            if (sample_acc && sample_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset discards any partial load by clearing ref_len.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ref_len   <= '0;
         scan_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         ref_len   <= ref_len_nxt;
         scan_done <= done_nxt;
      end
   end

   dtw_ref_out_reg #(
      .width (width)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (fetch_valid),
      .in_ready  (fetch_ready),
      .in_data   (mem_dataout),
      .in_last   (rd_ptr == (ref_len - LEN_ONE)),
      .out_valid (sample_valid),
      .out_ready (sample_ready),
      .out_data  (sample_data),
      .out_last  (sample_last)
   );

`ifdef DTW_REF_CTRL_STATS_EN
   localparam logic [CNT_WID-1:0] CNT_ONE = {{(CNT_WID-1){1'b0}}, 1'b1};
   logic [CNT_WID-1:0] scan_cnt;

   // Count completed scans, empty ones included, saturating instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
      end else if (done_nxt && (scan_cnt != '1)) begin
         scan_cnt <= scan_cnt + CNT_ONE;
      end
   end

   assign scan_count = scan_cnt;
`else
   assign scan_count = '0;
`endif

endmodule

// File: tb/tb_dtw_ref_mem_ctrl.sv
// Self-checking bench for dtw_ref_mem_ctrl with an 8-deep memory.
// Latency: checks scan timing of two cycles to first sample.
// Backpressure: exercises stalls on the sample stream and loads attempted mid-scan.
module tb_dtw_ref_mem_ctrl;

   localparam int W     = 16;
   localparam int P     = 3;
   localparam int DEPTH = 1 << P;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_valid, ld_ready, ld_last;
   logic [W-1:0]  ld_data;
   logic          scan_start, scan_busy, scan_done;
   logic          sample_valid, sample_ready, sample_last;
   logic [W-1:0]  sample_data;
   logic [P:0]    ref_len;
   logic [15:0]   scan_count;
   logic [P-1:0]  mem_addrR, mem_addrW;
   logic          mem_wren;
   logic [W-1:0]  mem_datain, mem_dataout;

   logic [W-1:0]  mem [DEPTH];

   // Reference model: expected memory image, loaded length, write address, completed scans.
   logic [W-1:0]  ref_mem [DEPTH];
   int            ref_len_m;
   int            wa;
   int            n_done;

   int            checks = 0;
   int            errors = 0;

   typedef struct {
      logic         vld;
      logic [W-1:0] dat;
      logic         lst;
      logic         ss;
      logic         e_wren;
      logic [P-1:0] e_addrw;
      logic [P:0]   e_len;
      logic         e_busy;
   } vec_t;

   vec_t tbl [7];

   dtw_ref_mem_ctrl #(.width(W), .ptrWid(P)) dut (
      .clk          (clk),
      .rst          (rst),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .scan_start   (scan_start),
      .scan_busy    (scan_busy),
      .scan_done    (scan_done),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_last  (sample_last),
      .ref_len      (ref_len),
      .scan_count   (scan_count),
      .mem_addrR    (mem_addrR),
      .mem_addrW    (mem_addrW),
      .mem_wren     (mem_wren),
      .mem_datain   (mem_datain),
      .mem_dataout  (mem_dataout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wren) mem[mem_addrW] <= mem_datain;
   end
   assign mem_dataout = mem[mem_addrR];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_count();
`ifdef DTW_REF_CTRL_STATS_EN
      return (n_done > 65535) ? 65535 : n_done;
`else
      return 0;
`endif
   endfunction

   // Spec rule: beats fill addresses upward; ld_last or the top address ends the load.
   task automatic model_beat(input logic [W-1:0] d, input logic last);
      ref_mem[wa] = d;
      if (last || wa == DEPTH - 1) begin
         ref_len_m = wa + 1;
         wa = 0;
      end else begin
         wa++;
      end
   endtask

   task automatic load_beat(input logic [W-1:0] d, input logic last, input int gaps);
      for (int g = 0; g < gaps; g++) begin
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         #1;
         chk("wren_gap", 32'(mem_wren), 32'd0);
         tick();
      end
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      #1;
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("mem_wren", 32'(mem_wren), 32'd1);
      chk("mem_addrW", 32'(mem_addrW), 32'(wa));
      chk("mem_datain", 32'(mem_datain), 32'(d));
      model_beat(d, last);
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // mode 0: ready always high, 1: ready 1,0,0 repeating with load pokes, 2: random ready.
   task automatic do_scan(input int mode);
      int       n, idx, done_at;
      logic     stall, finished;
      logic [W-1:0] pd;
      logic     pl;
      n = ref_len_m;
      idx = 0;
      done_at = (n == 0) ? 1 : -1;
      stall = 1'b0;
      finished = 1'b0;
      pd = '0;
      pl = 1'b0;
      for (int k = 0; k < 400 && !finished; k++) begin
         scan_start   = (k == 0);
         sample_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
         ld_valid     = 1'b0;
         ld_last      = 1'b0;
         #1;
         if (scan_busy) begin
            if (mode == 1) begin
               ld_valid = 1'b1;
               ld_data  = 16'hDEAD;
            end
            #1;
            chk("ld_ready_scan", 32'(ld_ready), 32'd0);
            chk("wren_scan", 32'(mem_wren), 32'd0);
         end
         if (k == done_at) begin
            chk("scan_done", 32'(scan_done), 32'd1);
            chk("scan_busy_end", 32'(scan_busy), 32'd0);
            chk("n_samples", 32'(idx), 32'(n));
            chk("valid_end", 32'(sample_valid), 32'd0);
            finished = 1'b1;
         end else begin
            chk("scan_done_low", 32'(scan_done), 32'd0);
            if (n > 0 && k >= 1) chk("scan_busy", 32'(scan_busy), 32'd1);
            if (n == 0) chk("no_valid", 32'(sample_valid), 32'd0);
            if (stall) begin
               chk("hold_valid", 32'(sample_valid), 32'd1);
               chk("hold_data", 32'(sample_data), 32'(pd));
               chk("hold_last", 32'(sample_last), 32'(pl));
            end
            if (sample_valid) begin
               if (mode == 0) chk("sample_cycle", 32'(k), 32'(idx + 2));
               stall = !sample_ready;
               pd = sample_data;
               pl = sample_last;
               if (sample_ready) begin
                  if (idx < n) begin
                     chk("sample_data", 32'(sample_data), 32'(ref_mem[idx]));
                     chk("sample_last", 32'(sample_last), 32'(idx == n - 1));
                  end else begin
                     chk("sample_count", 32'(idx + 1), 32'(n));
                  end
                  if (sample_last) done_at = k + 1;
                  idx++;
               end
            end else begin
               stall = 1'b0;
            end
            tick();
         end
      end
      if (!finished) chk("scan_timeout", 32'(idx), 32'(n + 1000));
      scan_start   = 1'b0;
      sample_ready = 1'b0;
      ld_valid     = 1'b0;
      n_done++;
      tick();
      chk("scan_count", 32'(scan_count), 32'(exp_count()));
   endtask

   task automatic do_reset();
      ld_valid = 1'b0;
      ld_last = 1'b0;
      scan_start = 1'b0;
      sample_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("ld_ready_in_rst", 32'(ld_ready), 32'd0);
      tick();
      rst = 1'b0;
      wa = 0;
      ref_len_m = 0;
      n_done = 0;
      #1;
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_ref_len", 32'(ref_len), 32'd0);
      chk("rst_busy", 32'(scan_busy), 32'd0);
      chk("rst_done", 32'(scan_done), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_count", 32'(scan_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1;
      ld_valid = 1'b0;
      ld_data = '0;
      ld_last = 1'b0;
      scan_start = 1'b0;
      sample_ready = 1'b0;
      wa = 0;
      ref_len_m = 0;
      n_done = 0;

      // Reset-state values.
      #1;
      chk("ld_ready_in_rst", 32'(ld_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("rst_busy", 32'(scan_busy), 32'd0);
      chk("rst_done", 32'(scan_done), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_sdata", 32'(sample_data), 32'd0);
      chk("rst_slast", 32'(sample_last), 32'd0);
      chk("rst_ref_len", 32'(ref_len), 32'd0);
      chk("rst_count", 32'(scan_count), 32'd0);
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_addrR", 32'(mem_addrR), 32'd0);
      chk("rst_addrW", 32'(mem_addrW), 32'd0);
      chk("rst_datain", 32'(mem_datain), 32'd0);
      tick();

      // Five-beat load with a gap and an ignored scan_start mid-load.
      tbl[0] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0};
      tbl[1] = '{1'b1, 16'h0012, 1'b0, 1'b0, 1'b1, 3'd1, 4'd0, 1'b0};
      tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
      tbl[3] = '{1'b1, 16'h0013, 1'b0, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0};
      tbl[4] = '{1'b1, 16'h0014, 1'b0, 1'b0, 1'b1, 3'd3, 4'd0, 1'b0};
      tbl[5] = '{1'b1, 16'h0015, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0, 1'b0};
      tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 1'b0};
      for (int i = 0; i < 7; i++) begin
         ld_valid   = tbl[i].vld;
         ld_data    = tbl[i].dat;
         ld_last    = tbl[i].lst;
         scan_start = tbl[i].ss;
         #1;
         chk("tbl_ld_ready", 32'(ld_ready), 32'd1);
         chk("tbl_wren", 32'(mem_wren), 32'(tbl[i].e_wren));
         chk("tbl_addrW", 32'(mem_addrW), 32'(tbl[i].e_addrw));
         chk("tbl_ref_len", 32'(ref_len), 32'(tbl[i].e_len));
         chk("tbl_busy", 32'(scan_busy), 32'(tbl[i].e_busy));
         if (tbl[i].vld) model_beat(tbl[i].dat, tbl[i].lst);
         tick();
      end
      ld_valid = 1'b0;
      scan_start = 1'b0;
      for (int i = 0; i < 5; i++) chk("mem_image", 32'(mem[i]), 32'h11 + 32'(i));

      do_scan(0);
      do_scan(1);
      do_scan(2);

      // Load beat and scan_start together: load wins, no scan.
      ld_valid = 1'b1;
      ld_data = 16'h0AAA;
      ld_last = 1'b1;
      scan_start = 1'b1;
      #1;
      chk("sim_wren", 32'(mem_wren), 32'd1);
      chk("sim_addrW", 32'(mem_addrW), 32'd0);
      model_beat(16'h0AAA, 1'b1);
      tick();
      ld_valid = 1'b0;
      ld_last = 1'b0;
      scan_start = 1'b0;
      #1;
      chk("sim_busy", 32'(scan_busy), 32'd0);
      chk("sim_ref_len", 32'(ref_len), 32'd1);
      tick();
      chk("sim_busy2", 32'(scan_busy), 32'd0);
      chk("sim_mem0", 32'(mem[0]), 32'h0AAA);
      do_scan(0);

      // Full memory without ld_last, then scan all eight.
      for (int i = 0; i < DEPTH; i++) load_beat(16'h0100 + 16'(i), 1'b0, 0);
      chk("full_ref_len", 32'(ref_len), 32'd8);
      do_scan(0);

      // Ten beats without ld_last: beats 9 and 10 open a new load at address 0.
      for (int i = 0; i < 10; i++) begin
         if (i == 8) chk("full10_ref_len", 32'(ref_len), 32'd8);
         load_beat(16'h0200 + 16'(i), 1'b0, 0);
      end
      load_beat(16'h02FF, 1'b1, 0);
      chk("tail_ref_len", 32'(ref_len), 32'd3);
      do_scan(2);

      // Reset in the middle of a load: nothing is left to scan.
      for (int i = 0; i < 3; i++) load_beat(16'h0300 + 16'(i), 1'b0, 0);
      do_reset();
      do_scan(0);

      // Randomized loads and scans against the model.
      for (int it = 0; it < 40; it++) begin
         int len;
         len = $urandom_range(1, 12);
         for (int b = 0; b < len; b++) load_beat(W'($urandom), b == len - 1, $urandom_range(0, 2));
         chk("rnd_ref_len", 32'(ref_len), 32'(ref_len_m));
         do_scan($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
